// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
package mul_hilo_pkg;

  localparam int unsigned CNT_W             = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDone
  } state_e;

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// Request/result bundle between a client and the HI/LO multiply controller.
interface mul_hilo_ctrl_if;
  import mul_hilo_pkg::*;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic [31:0] bus_in;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ovf;

  modport master (
    output start, a, b, abort, bus_in, hi_we, lo_we,
    input  busy, done, hi, lo, ovf
  );

  modport slave (
    input  start, a, b, abort, bus_in, hi_we, lo_we,
    output busy, done, hi, lo, ovf
  );

endinterface

// File: rtl/bp_booth_mul_32.sv
// Combinational radix-4 Booth multiplier: 32x32 signed -> 64-bit signed product.
module bp_booth_mul_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] z
);

  logic [32:0] w_bx;
  logic [63:0] w_ax;
  logic [63:0] w_pp;
  logic [63:0] w_acc;

  assign w_bx = {b, 1'b0};
  assign w_ax = {{32{a[31]}}, a};

  always_comb begin
    w_acc = '0;
    w_pp  = '0;
    for (int i = 0; i < 16; i++) begin
      case (w_bx[2*i +: 3])
        3'b001, 3'b010: w_pp = w_ax;
        3'b011:         w_pp = w_ax << 1;
        3'b100:         w_pp = -(w_ax << 1);
        3'b101, 3'b110: w_pp = -w_ax;
        default:        w_pp = '0;
      endcase
      w_acc = w_acc + (w_pp << (2 * i));
    end
    z = w_acc;
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Sequences a settle-timed combinational multiply into HI/LO with overflow flag,
// abort, and direct HI/LO loads.
module mul_hilo_ctrl
  import mul_hilo_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_hilo_ctrl_if.slave  bus
);

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [31:0]        r_op_a, w_op_a_d;
  logic [31:0]        r_op_b, w_op_b_d;
  logic [31:0]        r_hi, w_hi_d;
  logic [31:0]        r_lo, w_lo_d;
  logic               r_ovf, w_ovf_d;
  logic [63:0]        w_z;
  logic               w_last;

  bp_booth_mul_32 u_mul (
    .a (r_op_a),
    .b (r_op_b),
    .z (w_z)
  );

  assign w_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_op_a_d  = r_op_a;
    w_op_b_d  = r_op_b;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_ovf_d   = r_ovf;

    // Direct loads first so a same-edge capture below overrides them.
    if (bus.hi_we) w_hi_d = bus.bus_in;
    if (bus.lo_we) w_lo_d = bus.bus_in;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_op_a_d  = bus.a;
          w_op_b_d  = bus.b;
          w_ovf_d   = 1'b0;
          w_cnt_d   = '0;
          w_state_d = StSettle;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else if (w_last) begin
          w_hi_d    = w_z[63:32];
          w_lo_d    = w_z[31:0];
          w_ovf_d   = (w_z[63:32] != {32{w_z[31]}});
          w_cnt_d   = '0;
          w_state_d = StDone;
        end else begin
          w_cnt_d   = r_cnt + 1'b1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_op_a  <= w_op_a_d;
      r_op_b  <= w_op_b_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign bus.busy = (r_state == StSettle);
  assign bus.done = (r_state == StDone);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.ovf  = r_ovf;

endmodule
